// File: rtl/alu_seq_core.sv
// Button-driven sequential ALU: operand registers loaded on button edges, one op per
// execute edge, single-cycle ops via EXEC and a shift-add multiplier via MUL.
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [3:0]       opcode,
    input  logic             btn_load_a,
    input  logic             btn_load_b,
    input  logic             btn_execute,
    output logic [WIDTH-1:0] result_led,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             negative_flag,
    output logic             err_flag,
    output logic             busy,
    output logic             done
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_NOT = 4'd5,  OP_SHL = 4'd6,  OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8,  OP_ROR = 4'd9,  OP_ASR = 4'd10, OP_MUL  = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12, OP_PASS = 4'd13;

    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a, b, wa, wb;
    logic [3:0]         wop;
    logic [2:0]         btn_prev;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic ld_a_edge, ld_b_edge, ex_edge;
    assign ld_a_edge = btn_load_a  & ~btn_prev[0];
    assign ld_b_edge = btn_load_b  & ~btn_prev[1];
    assign ex_edge   = btn_execute & ~btn_prev[2];

    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    always_comb begin
        add_full = {1'b0, wa} + {1'b0, wb};
        sub_full = {1'b0, wa} - {1'b0, wb};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (wop)
            OP_ADD: begin
                alu_res = add_full[MSB:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (wa[MSB] == wb[MSB]) && (add_full[MSB] != wa[MSB]);
            end
            // sub_full[WIDTH] is the borrow: set exactly when A < B unsigned
            OP_SUB, OP_CMP: begin
                alu_res = sub_full[MSB:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (wa[MSB] != wb[MSB]) && (sub_full[MSB] != wa[MSB]);
            end
            OP_AND:  alu_res = wa & wb;
            OP_OR:   alu_res = wa | wb;
            OP_XOR:  alu_res = wa ^ wb;
            OP_NOT:  alu_res = ~wa;
            OP_SHL:  {alu_c, alu_res} = {wa, 1'b0};
            OP_SHR:  {alu_res, alu_c} = {1'b0, wa};
            OP_ROL: begin alu_res = {wa[MSB-1:0], wa[MSB]}; alu_c = wa[MSB]; end
            OP_ROR: begin alu_res = {wa[0], wa[MSB:1]};     alu_c = wa[0];   end
            OP_ASR: begin alu_res = {wa[MSB], wa[MSB:1]};   alu_c = wa[0];   end
            OP_PASS: alu_res = wb;
            default: ;
        endcase
    end

    // One shift-add step: multiplier sits in the low half and shifts out as the product grows
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_next;
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, wb} : '0);
        acc_next = {mul_sum, acc[MSB:1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            a             <= '0;
            b             <= '0;
            wa            <= '0;
            wb            <= '0;
            wop           <= '0;
            btn_prev      <= '0;
            acc           <= '0;
            cnt           <= '0;
            result_led    <= '0;
            result_hi     <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            negative_flag <= 1'b0;
            err_flag      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            btn_prev <= {btn_execute, btn_load_b, btn_load_a};
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_a_edge) a <= sw;
                    if (ld_b_edge) b <= sw;
                    if (ex_edge) begin
                        wa    <= a;
                        wb    <= b;
                        wop   <= opcode;
                        acc   <= {{WIDTH{1'b0}}, a};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= (opcode == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (wop > OP_PASS) begin
                        err_flag <= 1'b1;
                    end else begin
                        err_flag      <= 1'b0;
                        carry_flag    <= alu_c;
                        overflow_flag <= alu_v;
                        zero_flag     <= (alu_res == '0);
                        negative_flag <= alu_res[MSB];
                        if (wop != OP_CMP) begin
                            result_led <= alu_res;
                            result_hi  <= '0;
                        end
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        err_flag      <= 1'b0;
                        result_led    <= acc_next[MSB:0];
                        result_hi     <= acc_next[2*WIDTH-1:WIDTH];
                        zero_flag     <= (acc_next == '0);
                        carry_flag    <= |acc_next[2*WIDTH-1:WIDTH];
                        overflow_flag <= 1'b0;
                        negative_flag <= acc_next[MSB];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed expectations.
module tb_alu_seq_core;
    localparam int W = 8;
    localparam int M = 1 << W;
    localparam int H = M / 2;

    logic         clk = 1'b0, reset_n = 1'b0;
    logic [W-1:0] sw = '0;
    logic [3:0]   opcode = '0;
    logic         btn_load_a = 1'b0, btn_load_b = 1'b0, btn_execute = 1'b0;
    logic [W-1:0] result_led, result_hi;
    logic         zero_flag, carry_flag, overflow_flag, negative_flag, err_flag, busy, done;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .sw(sw), .opcode(opcode),
        .btn_load_a(btn_load_a), .btn_load_b(btn_load_b), .btn_execute(btn_execute),
        .result_led(result_led), .result_hi(result_hi),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .overflow_flag(overflow_flag),
        .negative_flag(negative_flag), .err_flag(err_flag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state
    int ma = 0, mb = 0, pa = 0, pb = 0, pe = 0, rem = 0;
    int s_a = 0, s_b = 0, s_op = 0;
    int m_res = 0, m_hi = 0, mz = 0, mc = 0, mv = 0, mn = 0, merr = 0, mdone = 0;

    task automatic apply();
        int x, y, sx, sy, r, p;
        x  = s_a;
        y  = s_b;
        sx = (x >= H) ? x - M : x;
        sy = (y >= H) ? y - M : y;
        r  = 0;
        if (s_op >= 14) begin
            merr = 1;
            return;
        end
        merr = 0; mc = 0; mv = 0;
        case (s_op)
            0: begin
                r  = (x + y) % M;
                mc = (x + y >= M) ? 1 : 0;
                mv = (sx + sy >= H || sx + sy < -H) ? 1 : 0;
            end
            1, 12: begin
                r  = (x - y + M) % M;
                mc = (x < y) ? 1 : 0;
                mv = (sx - sy >= H || sx - sy < -H) ? 1 : 0;
            end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = M - 1 - x;
            6: begin r = (x * 2) % M;         mc = (x >= H) ? 1 : 0; end
            7: begin r = x / 2;               mc = x % 2; end
            8: begin r = (x * 2) % M + x / H; mc = (x >= H) ? 1 : 0; end
            9: begin r = x / 2 + (x % 2) * H; mc = x % 2; end
            10: begin r = x / 2 + ((x >= H) ? H : 0); mc = x % 2; end
            11: begin
                p     = x * y;
                m_res = p % M;
                m_hi  = p / M;
                mc    = (m_hi != 0) ? 1 : 0;
                mz    = (p == 0) ? 1 : 0;
                mn    = (m_res >= H) ? 1 : 0;
                return;
            end
            13: r = y;
            default: ;
        endcase
        mz = (r == 0) ? 1 : 0;
        mn = (r >= H) ? 1 : 0;
        if (s_op != 12) begin
            m_res = r;
            m_hi  = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            ma = 0; mb = 0; pa = 0; pb = 0; pe = 0; rem = 0;
            m_res = 0; m_hi = 0; mz = 0; mc = 0; mv = 0; mn = 0; merr = 0; mdone = 0;
        end else begin
            mdone = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    apply();
                    mdone = 1;
                end
            end else begin
                if (btn_execute && pe == 0) begin
                    s_op = int'(opcode);
                    s_a  = ma;
                    s_b  = mb;
                    rem  = (opcode == 4'd11) ? W : 1;
                end
                if (btn_load_a && pa == 0) ma = int'(sw);
                if (btn_load_b && pb == 0) mb = int'(sw);
            end
            pa = btn_load_a ? 1 : 0;
            pb = btn_load_b ? 1 : 0;
            pe = btn_execute ? 1 : 0;
        end
    end

    initial forever begin
        @(negedge clk);
        check("result_led", int'(result_led), m_res);
        check("result_hi",  int'(result_hi),  m_hi);
        check("zero",       int'(zero_flag),  mz);
        check("carry",      int'(carry_flag), mc);
        check("overflow",   int'(overflow_flag), mv);
        check("negative",   int'(negative_flag), mn);
        check("err",        int'(err_flag),   merr);
        check("busy",       int'(busy),       (rem > 0) ? 1 : 0);
        check("done",       int'(done),       mdone);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_ab(input int va, input int vb);
        sw = W'(va); btn_load_a = 1'b1; tick(1); btn_load_a = 1'b0; tick(1);
        sw = W'(vb); btn_load_b = 1'b1; tick(1); btn_load_b = 1'b0; tick(1);
    endtask

    task automatic press_exec(input int op);
        opcode = 4'(op); btn_execute = 1'b1; tick(1); btn_execute = 1'b0;
    endtask

    // Counts negedges with busy high until done is seen (bounded)
    task automatic wait_done(output int bcnt);
        bcnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) bcnt++;
            tick(1);
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        int bc, npulse;
        tick(2);
        check("rst_result", int'(result_led), 0);
        check("rst_busy",   int'(busy), 0);
        check("rst_done",   int'(done), 0);
        reset_n = 1'b1;
        tick(1);

        load_ab(200, 100); press_exec(0);
        check("add_busy_first", int'(busy), 1);
        check("add_done_not_yet", int'(done), 0);
        wait_done(bc);
        check("add_busy_cycles", bc, 1);
        check("add_res", int'(result_led), 44);
        check("add_c", int'(carry_flag), 1);
        check("add_v", int'(overflow_flag), 0);
        check("add_z", int'(zero_flag), 0);
        check("add_n", int'(negative_flag), 0);
        tick(1);

        load_ab(5, 7); press_exec(1); wait_done(bc);
        check("sub_res", int'(result_led), 254);
        check("sub_c", int'(carry_flag), 1);
        check("sub_n", int'(negative_flag), 1);
        check("sub_v", int'(overflow_flag), 0);
        tick(1);

        load_ab(9, 9); press_exec(12); wait_done(bc);
        check("cmp_z", int'(zero_flag), 1);
        check("cmp_c", int'(carry_flag), 0);
        check("cmp_res_kept", int'(result_led), 254);
        tick(1);

        // MUL with load/execute presses while busy
        load_ab(16, 16); press_exec(11);
        sw = 8'h55; btn_load_a = 1'b1; btn_load_b = 1'b1; btn_execute = 1'b1;
        tick(2);
        btn_load_a = 1'b0; btn_load_b = 1'b0; btn_execute = 1'b0;
        wait_done(bc);
        check("mul_busy_cycles", bc + 2, 8);
        check("mul_lo", int'(result_led), 0);
        check("mul_hi", int'(result_hi), 1);
        check("mul_c", int'(carry_flag), 1);
        check("mul_z", int'(zero_flag), 0);
        tick(1);
        press_exec(0); wait_done(bc);
        check("ab_unchanged_add", int'(result_led), 32);
        check("hi_cleared", int'(result_hi), 0);
        tick(1);

        load_ab(127, 1); press_exec(0); wait_done(bc);
        check("ovf_res", int'(result_led), 128);
        check("ovf_v", int'(overflow_flag), 1);
        check("ovf_n", int'(negative_flag), 1);
        tick(1);

        load_ab(8'h01, 1); press_exec(9); wait_done(bc);
        check("ror_res", int'(result_led), 8'h80);
        check("ror_c", int'(carry_flag), 1);
        tick(1);
        load_ab(8'h80, 1); press_exec(10); wait_done(bc);
        check("asr_res", int'(result_led), 8'hC0);
        check("asr_c", int'(carry_flag), 0);
        tick(1);

        // Held execute yields one operation (PASS B, B=1)
        opcode = 4'd13; btn_execute = 1'b1; npulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (done) npulse++;
        end
        btn_execute = 1'b0;
        tick(3);
        check("held_one_done", npulse, 1);
        check("pass_res", int'(result_led), 1);

        press_exec(14); wait_done(bc);
        check("illegal_err", int'(err_flag), 1);
        check("illegal_res_kept", int'(result_led), 1);
        tick(1);
        load_ab(3, 4); press_exec(0); wait_done(bc);
        check("err_cleared", int'(err_flag), 0);
        check("add2_res", int'(result_led), 7);
        tick(1);

        // Reset during MUL
        load_ab(15, 17); press_exec(11);
        tick(2);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_res", int'(result_led), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        tick(2);
        reset_n = 1'b1;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (done) npulse++;
        end
        check("no_done_after_abort", npulse, 0);
        load_ab(15, 17); press_exec(11); wait_done(bc);
        check("mul2_lo", int'(result_led), 255);
        check("mul2_hi", int'(result_hi), 0);
        check("mul2_c", int'(carry_flag), 0);
        check("mul2_n", int'(negative_flag), 1);
        tick(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1);
    end
endmodule
